// File: rtl/noc_arb_pkg.sv
// rtl/noc_arb_pkg.sv - shared types and round-robin helper for the injection arbiter
//
// Purpose: arbiter FSM state encoding and the rotating first-set-bit search.
// Contents:
//   arb_state_e : IDLE (arbitrating) / LOCKED (streaming one packet)
//   rr_pick     : first set index of req at or after ptr, modulo n (n <= 16)
package noc_arb_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  localparam int unsigned RR_MAX_REQ = 16;

  // Caller guarantees at least one req bit below n is set; otherwise 0 is returned.
  function automatic logic [3:0] rr_pick(input logic [RR_MAX_REQ-1:0] req,
                                         input logic [3:0]            ptr,
                                         input int unsigned           n);
    logic [3:0]  pick;
    logic        found;
    int unsigned idx;
    pick  = '0;
    found = 1'b0;
    for (int unsigned off = 0; off < RR_MAX_REQ; off++) begin
      idx = (32'(ptr) + off) % n;
      if (!found && (off < n) && req[4'(idx)]) begin
        pick  = 4'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/axis_pipe_fifo2.sv
// rtl/axis_pipe_fifo2.sv - 2-entry register FIFO decoupling the router port from the sources
//
// Purpose: holds up to two beats so the upstream accept never waits on the
// downstream ready in the same cycle.
// Ports:
//   clk_i, rst_i           : clock, synchronous active-high reset
//   push_i, push_data_i    : write strobe and beat; ignored while full_o
//   full_o                 : both entries occupied
//   pop_i                  : consumer ready; pops when valid_o
//   valid_o, pop_data_o    : head beat present / head beat contents
module axis_pipe_fifo2 #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  output logic             full_o,
  input  logic             pop_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] pop_data_o
);

  logic [WIDTH-1:0] mem_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       count_q;
  logic [1:0]       count_d;
  logic             push_en;
  logic             pop_en;

  assign full_o     = (count_q == 2'd2);
  assign valid_o    = (count_q != 2'd0);
  assign pop_data_o = mem_q[rd_ptr_q];
  assign push_en    = push_i & ~full_o;
  assign pop_en     = pop_i & valid_o;

  always_comb begin
    count_d = count_q;
    case ({push_en, pop_en})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Entries are cleared on reset so the head fields read as zero afterwards.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_en) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_en) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/axis_inject_arbiter.sv
// rtl/axis_inject_arbiter.sv - packet-granular round-robin arbiter onto one router injection port
//
// Purpose: shares the router axis_in_* port among NUM_REQ sources; a grant is
// held until the granted source's tlast beat is accepted.
// Ports:
//   clk_usr, rst_usr_sync        : user clock, synchronous active-high reset
//   s_axis_*                     : per-source streams, source i at slice i
//   req_enable                   : static mask; cleared sources are never newly granted
//   m_axis_*                     : buffered output towards the router
//   grant_valid, grant_idx       : lock status and locked source
module axis_inject_arbiter
  import noc_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ       = 4,
  parameter int unsigned TDATA_WIDTH   = 64,
  parameter int unsigned TID_WIDTH     = 2,
  parameter int unsigned TDEST_WIDTH   = 2,
  parameter int unsigned REQ_IDX_WIDTH = $clog2(NUM_REQ)
) (
  input  logic                           clk_usr,
  input  logic                           rst_usr_sync,
  input  logic [NUM_REQ-1:0]             s_axis_tvalid,
  output logic [NUM_REQ-1:0]             s_axis_tready,
  input  logic [NUM_REQ*TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_REQ-1:0]             s_axis_tlast,
  input  logic [NUM_REQ*TID_WIDTH-1:0]   s_axis_tid,
  input  logic [NUM_REQ*TDEST_WIDTH-1:0] s_axis_tdest,
  input  logic [NUM_REQ-1:0]             req_enable,
  output logic                           m_axis_tvalid,
  input  logic                           m_axis_tready,
  output logic [TDATA_WIDTH-1:0]         m_axis_tdata,
  output logic                           m_axis_tlast,
  output logic [TID_WIDTH-1:0]           m_axis_tid,
  output logic [TDEST_WIDTH-1:0]         m_axis_tdest,
  output logic                           grant_valid,
  output logic [REQ_IDX_WIDTH-1:0]       grant_idx
);

  localparam int unsigned BEAT_W = TDATA_WIDTH + TID_WIDTH + TDEST_WIDTH + 1;

  arb_state_e               state_q, state_d;
  logic [REQ_IDX_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
  logic [REQ_IDX_WIDTH-1:0] grant_idx_q, grant_idx_d;
  logic [NUM_REQ-1:0]       cand;
  logic                     fifo_full;
  logic                     fifo_valid;
  logic                     sel_valid;
  logic                     sel_last;
  logic                     accept;
  logic [BEAT_W-1:0]        sel_beat;
  logic [BEAT_W-1:0]        head_beat;
  int unsigned              sel;

  assign cand = s_axis_tvalid & req_enable;

  // Mux of the locked source onto the FIFO input.
  always_comb begin
    sel       = 32'(grant_idx_q);
    sel_valid = s_axis_tvalid[grant_idx_q];
    sel_last  = s_axis_tlast[grant_idx_q];
    sel_beat  = {s_axis_tdata[sel*TDATA_WIDTH +: TDATA_WIDTH],
                 s_axis_tid[sel*TID_WIDTH +: TID_WIDTH],
                 s_axis_tdest[sel*TDEST_WIDTH +: TDEST_WIDTH],
                 sel_last};
  end

  // IDLE only arbitrates; beats flow solely in LOCKED, so each packet pays
  // one arbitration cycle. req_enable is only consulted when picking.
  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    grant_idx_d   = grant_idx_q;
    s_axis_tready = '0;
    accept        = 1'b0;
    case (state_q)
      IDLE: begin
        if (|cand) begin
          grant_idx_d = REQ_IDX_WIDTH'(rr_pick(16'(cand), 4'(rr_ptr_q), NUM_REQ));
          state_d     = LOCKED;
        end
      end
      LOCKED: begin
        s_axis_tready[grant_idx_q] = ~fifo_full;
        accept = sel_valid & ~fifo_full;
        if (accept && sel_last) begin
          state_d  = IDLE;
          rr_ptr_d = (grant_idx_q == REQ_IDX_WIDTH'(NUM_REQ - 1)) ? '0
                     : grant_idx_q + REQ_IDX_WIDTH'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_usr) begin
    if (rst_usr_sync) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      grant_idx_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_idx_q <= grant_idx_d;
    end
  end

  axis_pipe_fifo2 #(
    .WIDTH(BEAT_W)
  ) u_fifo (
    .clk_i       (clk_usr),
    .rst_i       (rst_usr_sync),
    .push_i      (accept),
    .push_data_i (sel_beat),
    .full_o      (fifo_full),
    .pop_i       (m_axis_tready),
    .valid_o     (fifo_valid),
    .pop_data_o  (head_beat)
  );

  assign m_axis_tvalid = fifo_valid;
  assign {m_axis_tdata, m_axis_tid, m_axis_tdest, m_axis_tlast} = head_beat;
  assign grant_valid   = (state_q == LOCKED);
  assign grant_idx     = grant_idx_q;

endmodule

// File: tb/tb_axis_inject_arbiter.sv
// tb/tb_axis_inject_arbiter.sv - self-checking bench for axis_inject_arbiter
module tb_axis_inject_arbiter;

  localparam int NR   = 4;
  localparam int DW   = 64;
  localparam int IW   = 2;
  localparam int DSTW = 2;
  localparam int XW   = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     s_axis_tvalid;
  logic [NR-1:0]     s_axis_tready;
  logic [NR*DW-1:0]  s_axis_tdata;
  logic [NR-1:0]     s_axis_tlast;
  logic [NR*IW-1:0]  s_axis_tid;
  logic [NR*DSTW-1:0] s_axis_tdest;
  logic [NR-1:0]     req_enable;
  logic              m_axis_tvalid;
  logic              m_axis_tready;
  logic [DW-1:0]     m_axis_tdata;
  logic              m_axis_tlast;
  logic [IW-1:0]     m_axis_tid;
  logic [DSTW-1:0]   m_axis_tdest;
  logic              grant_valid;
  logic [XW-1:0]     grant_idx;

  always #5 clk = ~clk;

  axis_inject_arbiter #(
    .NUM_REQ(NR), .TDATA_WIDTH(DW), .TID_WIDTH(IW), .TDEST_WIDTH(DSTW), .REQ_IDX_WIDTH(XW)
  ) dut (
    .clk_usr(clk), .rst_usr_sync(rst),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tdata(s_axis_tdata),
    .s_axis_tlast(s_axis_tlast), .s_axis_tid(s_axis_tid), .s_axis_tdest(s_axis_tdest),
    .req_enable(req_enable),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tdata(m_axis_tdata),
    .m_axis_tlast(m_axis_tlast), .m_axis_tid(m_axis_tid), .m_axis_tdest(m_axis_tdest),
    .grant_valid(grant_valid), .grant_idx(grant_idx)
  );

  int checks = 0;
  int errors = 0;

  // Source models: beat tdata = {src, pkt, beat} in the low 24 bits.
  logic [NR-1:0] src_en;
  logic [NR-1:0] src_hold;
  int            src_pkt  [NR];
  int            src_beat [NR];
  int            len_tab  [NR][4];

  logic [DW-1:0] out_data [$];
  logic [IW-1:0] out_tid  [$];
  logic          out_last [$];

  typedef struct {
    logic [3:0] valid;
    logic [7:0] data;
    logic       last;
    logic       mrdy;
    logic [3:0] e_srdy;
    logic       e_mv;
    logic [7:0] e_md;
    logic       e_ml;
    logic       e_gv;
    logic [1:0] e_gi;
  } vec_t;

  vec_t vt [15];

  function automatic vec_t mk(logic [3:0] v, logic [7:0] d, logic l, logic r, logic [3:0] es,
                              logic emv, logic [7:0] emd, logic eml, logic egv, logic [1:0] egi);
    vec_t x;
    x.valid = v; x.data = d; x.last = l; x.mrdy = r; x.e_srdy = es;
    x.e_mv = emv; x.e_md = emd; x.e_ml = eml; x.e_gv = egv; x.e_gi = egi;
    return x;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_src();
    for (int i = 0; i < NR; i++) begin
      s_axis_tvalid[i] = src_en[i] & ~src_hold[i];
      s_axis_tdata[i*DW +: DW] = {40'h0, 8'(i), 8'(src_pkt[i]), 8'(src_beat[i])};
      s_axis_tid[i*IW +: IW] = 2'(i);
      s_axis_tdest[i*DSTW +: DSTW] = 2'(3 - i);
      s_axis_tlast[i] = (src_beat[i] == len_tab[i][src_pkt[i] % 4] - 1);
    end
  endtask

  // Called mid-cycle: records handshakes, crosses the edge, advances sources.
  task automatic step();
    logic [NR-1:0] hs;
    hs = s_axis_tvalid & s_axis_tready;
    if (m_axis_tvalid && m_axis_tready) begin
      out_data.push_back(m_axis_tdata);
      out_tid.push_back(m_axis_tid);
      out_last.push_back(m_axis_tlast);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++) begin
      if (hs[i]) begin
        if (s_axis_tlast[i]) begin
          src_beat[i] = 0;
          src_pkt[i]++;
        end else begin
          src_beat[i]++;
        end
      end
    end
    drive_src();
  endtask

  task automatic run(input int n);
    repeat (n) begin
      #3;
      step();
    end
  endtask

  task automatic reset_all();
    rst = 1'b1;
    src_en = '0;
    src_hold = '0;
    m_axis_tready = 1'b1;
    req_enable = 4'b1111;
    for (int i = 0; i < NR; i++) begin
      src_pkt[i] = 0;
      src_beat[i] = 0;
      for (int p = 0; p < 4; p++) len_tab[i][p] = 1;
    end
    drive_src();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    out_data.delete();
    out_tid.delete();
    out_last.delete();
  endtask

  task automatic exp_out(input int k, input int s, input int p, input int b, input logic l);
    if (k >= out_data.size()) begin
      checks++;
      errors++;
      $display("FAIL out%0d_missing: got %0d beats, required more than %0d", k, out_data.size(), k);
    end else begin
      chk($sformatf("out%0d_data", k), out_data[k], {40'h0, 8'(s), 8'(p), 8'(b)});
      chk($sformatf("out%0d_tid", k), 64'(out_tid[k]), 64'(s));
      chk($sformatf("out%0d_last", k), 64'(out_last[k]), 64'(l));
    end
  endtask

  initial begin
    int  hold_left;
    bit  held;
    bit  cleared;

    // Test 1 (rows 0-5) and FIFO-full stall (rows 6-14), source 0 only.
    vt[0]  = mk(4'b0001, 8'h11, 0, 1, 4'b0000, 0, 8'h00, 0, 0, 2'd0);
    vt[1]  = mk(4'b0001, 8'h11, 0, 1, 4'b0001, 0, 8'h00, 0, 1, 2'd0);
    vt[2]  = mk(4'b0001, 8'h22, 0, 1, 4'b0001, 1, 8'h11, 0, 1, 2'd0);
    vt[3]  = mk(4'b0001, 8'h33, 1, 1, 4'b0001, 1, 8'h22, 0, 1, 2'd0);
    vt[4]  = mk(4'b0000, 8'h00, 0, 1, 4'b0000, 1, 8'h33, 1, 0, 2'd0);
    vt[5]  = mk(4'b0000, 8'h00, 0, 1, 4'b0000, 0, 8'h00, 0, 0, 2'd0);
    vt[6]  = mk(4'b0001, 8'hA1, 0, 0, 4'b0000, 0, 8'h00, 0, 0, 2'd0);
    vt[7]  = mk(4'b0001, 8'hA1, 0, 0, 4'b0001, 0, 8'h00, 0, 1, 2'd0);
    vt[8]  = mk(4'b0001, 8'hA2, 0, 0, 4'b0001, 1, 8'hA1, 0, 1, 2'd0);
    vt[9]  = mk(4'b0001, 8'hA3, 0, 0, 4'b0000, 1, 8'hA1, 0, 1, 2'd0);
    vt[10] = mk(4'b0001, 8'hA3, 0, 1, 4'b0000, 1, 8'hA1, 0, 1, 2'd0);
    vt[11] = mk(4'b0001, 8'hA3, 0, 1, 4'b0001, 1, 8'hA2, 0, 1, 2'd0);
    vt[12] = mk(4'b0001, 8'hA4, 1, 1, 4'b0001, 1, 8'hA3, 0, 1, 2'd0);
    vt[13] = mk(4'b0000, 8'h00, 0, 1, 4'b0000, 1, 8'hA4, 1, 0, 2'd0);
    vt[14] = mk(4'b0000, 8'h00, 0, 1, 4'b0000, 0, 8'h00, 0, 0, 2'd0);

    reset_all();
    #3;
    chk("rst_m_tvalid", 64'(m_axis_tvalid), 0);
    chk("rst_m_tdata", m_axis_tdata, 0);
    chk("rst_s_tready", 64'(s_axis_tready), 0);
    chk("rst_grant_valid", 64'(grant_valid), 0);
    chk("rst_grant_idx", 64'(grant_idx), 0);
    @(posedge clk); #1;

    for (int r = 0; r < 15; r++) begin
      s_axis_tvalid = vt[r].valid;
      s_axis_tdata = '0;
      s_axis_tdata[7:0] = vt[r].data;
      s_axis_tlast = {3'b000, vt[r].last};
      s_axis_tid = '0;
      s_axis_tdest = '0;
      m_axis_tready = vt[r].mrdy;
      #3;
      chk($sformatf("vec%0d_s_tready", r), 64'(s_axis_tready), 64'(vt[r].e_srdy));
      chk($sformatf("vec%0d_m_tvalid", r), 64'(m_axis_tvalid), 64'(vt[r].e_mv));
      if (vt[r].e_mv) begin
        chk($sformatf("vec%0d_m_tdata", r), m_axis_tdata, 64'(vt[r].e_md));
        chk($sformatf("vec%0d_m_tlast", r), 64'(m_axis_tlast), 64'(vt[r].e_ml));
      end
      chk($sformatf("vec%0d_grant_valid", r), 64'(grant_valid), 64'(vt[r].e_gv));
      chk($sformatf("vec%0d_grant_idx", r), 64'(grant_idx), 64'(vt[r].e_gi));
      @(posedge clk); #1;
    end

    // Round robin over four always-valid single-beat sources.
    reset_all();
    src_en = 4'b1111;
    drive_src();
    for (int c = 0; c < 12; c++) begin
      #3;
      chk($sformatf("rr_gv_c%0d", c), 64'(grant_valid), 64'(c % 2));
      step();
    end
    run(2);
    for (int k = 0; k < 6; k++) exp_out(k, k % 4, k / 4, 0, 1'b1);

    // Lock survives a 5-cycle tvalid gap on source 1 while source 2 waits.
    reset_all();
    len_tab[1][0] = 3;
    src_en = 4'b0110;
    drive_src();
    held = 0;
    hold_left = 0;
    for (int c = 0; c < 16; c++) begin
      if (!held && src_beat[1] == 1) begin
        held = 1;
        hold_left = 5;
      end
      src_hold[1] = (hold_left > 0);
      drive_src();
      #3;
      if (hold_left > 0) begin
        chk("gap_grant_valid", 64'(grant_valid), 1);
        chk("gap_grant_idx", 64'(grant_idx), 1);
        chk("gap_s_tready", 64'(s_axis_tready), 64'(4'b0010));
        hold_left--;
      end
      step();
    end
    exp_out(0, 1, 0, 0, 1'b0);
    exp_out(1, 1, 0, 1, 1'b0);
    exp_out(2, 1, 0, 2, 1'b1);
    exp_out(3, 2, 0, 0, 1'b1);
    exp_out(4, 1, 1, 0, 1'b1);

    // Enable mask 1011, then source 0 disabled mid-packet.
    reset_all();
    req_enable = 4'b1011;
    len_tab[0][1] = 3;
    src_en = 4'b1111;
    drive_src();
    cleared = 0;
    for (int c = 0; c < 24; c++) begin
      if (!cleared && src_pkt[0] == 1 && src_beat[0] == 1) begin
        req_enable[0] = 1'b0;
        cleared = 1;
        #3;
        chk("clr_grant_valid", 64'(grant_valid), 1);
        chk("clr_grant_idx", 64'(grant_idx), 0);
        step();
      end else begin
        #3;
        step();
      end
    end
    exp_out(0, 0, 0, 0, 1'b1);
    exp_out(1, 1, 0, 0, 1'b1);
    exp_out(2, 3, 0, 0, 1'b1);
    exp_out(3, 0, 1, 0, 1'b0);
    exp_out(4, 0, 1, 1, 1'b0);
    exp_out(5, 0, 1, 2, 1'b1);
    exp_out(6, 1, 1, 0, 1'b1);
    exp_out(7, 3, 1, 0, 1'b1);
    exp_out(8, 1, 2, 0, 1'b1);
    exp_out(9, 3, 2, 0, 1'b1);

    // Reset mid-packet with the FIFO full.
    reset_all();
    m_axis_tready = 1'b0;
    len_tab[1][0] = 4;
    src_en = 4'b0010;
    drive_src();
    run(3);
    #3;
    chk("full_s_tready", 64'(s_axis_tready), 0);
    chk("full_grant_idx", 64'(grant_idx), 1);
    chk("full_m_tdata", m_axis_tdata, {40'h0, 8'd1, 8'd0, 8'd0});
    rst = 1'b1;
    src_en = 4'b0011;
    drive_src();
    step();
    rst = 1'b0;
    #3;
    chk("post_rst_m_tvalid", 64'(m_axis_tvalid), 0);
    chk("post_rst_m_tdata", m_axis_tdata, 0);
    chk("post_rst_s_tready", 64'(s_axis_tready), 0);
    chk("post_rst_grant_valid", 64'(grant_valid), 0);
    chk("post_rst_grant_idx", 64'(grant_idx), 0);
    step();
    #3;
    chk("post_rst_regrant_valid", 64'(grant_valid), 1);
    chk("post_rst_regrant_idx", 64'(grant_idx), 0);
    chk("post_rst_regrant_ready", 64'(s_axis_tready), 64'(4'b0001));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
